// File: rtl/column_drop_ctrl_if.sv
// column_drop_ctrl_if: drop request bus; master drives valid/col, slave returns ready/done/ok/row
interface column_drop_ctrl_if;
  logic       valid;
  logic [2:0] col;
  logic       ready;
  logic       done;
  logic       ok;
  logic [2:0] row;
  modport master(output valid, col, input ready, done, ok, row);
  modport slave(input valid, col, output ready, done, ok, row);
endinterface

// File: rtl/column_drop_ctrl.sv
// column_drop_ctrl: Connect Four 7x6 board keeper and drop sequencer; ports clk/resetn, board_clear, drop bus (column_drop_ctrl_if.slave), turn, anim_active/anim_col/anim_row, rd_col -> rd_occ/rd_color; define DROP_ANIM_EN for the row-by-row FALL animation
module column_drop_ctrl #(
  parameter int FALL_TICKS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              board_clear,
  column_drop_ctrl_if.slave drop,
  output logic              turn,
  output logic              anim_active,
  output logic [2:0]        anim_col,
  output logic [2:0]        anim_row,
  input  logic [2:0]        rd_col,
  output logic [5:0]        rd_occ,
  output logic [5:0]        rd_color
);
  localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, FALL = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [2:0] col_q, col_d, row_q, row_d, h, wr_h;
  logic [6:0][5:0] occ_q, occ_d, color_q, color_d;
  logic turn_q, turn_d, ok_q, ok_d, full, place;
`ifdef DROP_ANIM_EN
  localparam int TW = FALL_TICKS > 1 ? $clog2(FALL_TICKS) : 1;
  logic [2:0] h_q, h_d, arow_q, arow_d;
  logic [TW-1:0] tick_q, tick_d;
  logic last;
  assign last = tick_q == TW'(FALL_TICKS - 1);
  assign anim_col = col_q;
  assign anim_row = arow_q;
`else
  assign anim_col = 3'd0;
  assign anim_row = 3'd0;
`endif
  assign full = col_q > 3'd6 || &occ_q[col_q];
  assign h = 3'($countones(occ_q[col_q]));
  assign drop.ready = state_q == IDLE;
  assign drop.done = state_q == DONE;
  assign drop.ok = ok_q;
  assign drop.row = row_q;
  assign turn = turn_q;
  assign anim_active = state_q == FALL;
  assign rd_occ = rd_col > 3'd6 ? 6'd0 : occ_q[rd_col];
  assign rd_color = rd_col > 3'd6 ? 6'd0 : color_q[rd_col];
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    ok_d = ok_q;
    turn_d = turn_q;
    occ_d = occ_q;
    color_d = color_q;
`ifdef DROP_ANIM_EN
    h_d = h_q;
    arow_d = arow_q;
    tick_d = tick_q;
    place = state_q == FALL && last && arow_q == h_q;
    wr_h = h_q;
`else
    place = state_q == CHECK && !full;
    wr_h = h;
`endif
    if (state_q == IDLE && drop.valid) begin
      state_d = CHECK;
      col_d = drop.col;
    end
    if (state_q == CHECK && full) begin
      state_d = DONE;
      ok_d = 1'b0;
    end
`ifdef DROP_ANIM_EN
    if (state_q == CHECK && !full) begin
      state_d = FALL;
      h_d = h;
      arow_d = 3'd5;
      tick_d = '0;
    end
    if (state_q == FALL) begin
      tick_d = last ? '0 : tick_q + 1'b1;
      arow_d = last && arow_q != h_q ? arow_q - 3'd1 : arow_q;
    end
`endif
    if (place) begin
      occ_d[col_q][wr_h] = 1'b1;
      color_d[col_q][wr_h] = turn_q;
      row_d = wr_h;
      ok_d = 1'b1;
      turn_d = !turn_q;
      state_d = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
    if (board_clear) begin
      state_d = IDLE;
      occ_d = '0;
      color_d = '0;
      turn_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      ok_q <= 1'b0;
      turn_q <= 1'b0;
      occ_q <= '0;
      color_q <= '0;
`ifdef DROP_ANIM_EN
      h_q <= '0;
      arow_q <= '0;
      tick_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      ok_q <= ok_d;
      turn_q <= turn_d;
      occ_q <= occ_d;
      color_q <= color_d;
`ifdef DROP_ANIM_EN
      h_q <= h_d;
      arow_q <= arow_d;
      tick_q <= tick_d;
`endif
    end
endmodule

// File: tb/tb_column_drop_ctrl.sv
// tb_column_drop_ctrl: table-driven drop sequence plus clear/reset corner cases for column_drop_ctrl
module tb_column_drop_ctrl;
  localparam int FT = 2;
`ifdef DROP_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif
  localparam int ABORT_AT = ANIM ? 6 : 1;
  localparam int RST_AT = ANIM ? 4 : 1;
  logic clk = 1'b0, resetn = 1'b0, board_clear = 1'b0;
  logic turn, anim_active;
  logic [2:0] anim_col, anim_row;
  logic [2:0] rd_col = 3'd0;
  logic [5:0] rd_occ, rd_color;
  int asserts = 0, fails = 0;
  column_drop_ctrl_if dif();
  column_drop_ctrl #(.FALL_TICKS(FT)) dut (
    .clk(clk), .resetn(resetn), .board_clear(board_clear), .drop(dif.slave),
    .turn(turn), .anim_active(anim_active), .anim_col(anim_col), .anim_row(anim_row),
    .rd_col(rd_col), .rd_occ(rd_occ), .rd_color(rd_color)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] col;
    bit         ok;
    logic [2:0] row;
    bit         turn;
    logic [5:0] occ;
    logic [5:0] color;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_board_empty(input string name);
    for (int c = 0; c < 7; c++) begin
      rd_col = 3'(c);
      #1;
      chk(name, int'(rd_occ), 0);
      chk(name, int'(rd_color), 0);
    end
  endtask
  function automatic int exp_lat(input bit ok, input logic [2:0] row);
    return (ANIM && ok) ? 2 + (6 - int'(row)) * FT : 2;
  endfunction
  task automatic do_drop(input logic [2:0] c, input bit ok, output int lat, output int aerr);
    bit exp_act;
    lat = 0;
    aerr = 0;
    dif.valid = 1'b1;
    dif.col = c;
    rd_col = c;
    @(negedge clk);
    dif.valid = 1'b0;
    for (int n = 1; n < 100 && lat == 0; n++) begin
      if (dif.done) lat = n;
      else begin
        exp_act = ANIM && ok && n >= 2;
        if (anim_active != exp_act) aerr++;
        if (exp_act && (anim_row != 3'(5 - (n - 2) / FT) || anim_col != c)) aerr++;
        @(negedge clk);
      end
    end
  endtask
  initial begin
    int lat, aerr;
    bit seen;
    vt[0]  = '{3'd0, 1'b1, 3'd0, 1'b1, 6'b000001, 6'b000000};
    vt[1]  = '{3'd0, 1'b1, 3'd1, 1'b0, 6'b000011, 6'b000010};
    vt[2]  = '{3'd0, 1'b1, 3'd2, 1'b1, 6'b000111, 6'b000010};
    vt[3]  = '{3'd0, 1'b1, 3'd3, 1'b0, 6'b001111, 6'b001010};
    vt[4]  = '{3'd0, 1'b1, 3'd4, 1'b1, 6'b011111, 6'b001010};
    vt[5]  = '{3'd0, 1'b1, 3'd5, 1'b0, 6'b111111, 6'b101010};
    vt[6]  = '{3'd0, 1'b0, 3'd5, 1'b0, 6'b111111, 6'b101010};
    vt[7]  = '{3'd7, 1'b0, 3'd5, 1'b0, 6'b000000, 6'b000000};
    vt[8]  = '{3'd3, 1'b1, 3'd0, 1'b1, 6'b000001, 6'b000000};
    vt[9]  = '{3'd3, 1'b1, 3'd1, 1'b0, 6'b000011, 6'b000010};
    vt[10] = '{3'd3, 1'b1, 3'd2, 1'b1, 6'b000111, 6'b000010};
    dif.valid = 1'b0;
    dif.col = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(dif.ready), 1);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_ok", int'(dif.ok), 0);
    chk("rst_row", int'(dif.row), 0);
    chk("rst_turn", int'(turn), 0);
    chk("rst_anim_active", int'(anim_active), 0);
    chk("rst_anim_col", int'(anim_col), 0);
    chk("rst_anim_row", int'(anim_row), 0);
    chk_board_empty("rst_board");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(dif.ready), 1);
    for (int i = 0; i < 11; i++) begin
      do_drop(vt[i].col, vt[i].ok, lat, aerr);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vt[i].ok, vt[i].row));
      chk($sformatf("v%0d_anim", i), aerr, 0);
      chk($sformatf("v%0d_ok", i), int'(dif.ok), int'(vt[i].ok));
      chk($sformatf("v%0d_row", i), int'(dif.row), int'(vt[i].row));
      chk($sformatf("v%0d_turn", i), int'(turn), int'(vt[i].turn));
      chk($sformatf("v%0d_occ", i), int'(rd_occ), int'(vt[i].occ));
      chk($sformatf("v%0d_color", i), int'(rd_color), int'(vt[i].color));
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), int'(dif.ready), 1);
      chk($sformatf("v%0d_done_pulse", i), int'(dif.done), 0);
    end
    rd_col = 3'd0;
    #1;
    chk("col0_occ_kept", int'(rd_occ), 6'b111111);
    chk("col0_color_kept", int'(rd_color), 6'b101010);
    rd_col = 3'd5;
    #1;
    chk("col5_untouched", int'(rd_occ), 0);
    dif.valid = 1'b1;
    dif.col = 3'd1;
    rd_col = 3'd1;
    @(negedge clk);
    dif.valid = 1'b0;
    seen = 1'b0;
    for (int n = 1; n < ABORT_AT; n++) begin
      seen |= dif.done;
      @(negedge clk);
    end
    seen |= dif.done;
    chk("abort_mid_fall", int'(anim_active), int'(ANIM));
    board_clear = 1'b1;
    @(negedge clk);
    board_clear = 1'b0;
    seen |= dif.done;
    chk("abort_no_done", int'(seen), 0);
    chk("abort_ready", int'(dif.ready), 1);
    chk("abort_turn", int'(turn), 0);
    chk_board_empty("abort_board");
    @(negedge clk);
    dif.valid = 1'b1;
    dif.col = 3'd2;
    board_clear = 1'b1;
    @(negedge clk);
    dif.valid = 1'b0;
    board_clear = 1'b0;
    chk("clr_valid_ready", int'(dif.ready), 1);
    seen = 1'b0;
    repeat (3) begin
      seen |= dif.done | ~dif.ready;
      @(negedge clk);
    end
    chk("clr_valid_no_accept", int'(seen), 0);
    rd_col = 3'd2;
    #1;
    chk("clr_valid_col2", int'(rd_occ), 0);
    @(negedge clk);
    do_drop(3'd4, 1'b1, lat, aerr);
    chk("pre_rst_latency", lat, exp_lat(1'b1, 3'd0));
    chk("pre_rst_occ", int'(rd_occ), 6'b000001);
    @(negedge clk);
    dif.valid = 1'b1;
    dif.col = 3'd2;
    @(negedge clk);
    dif.valid = 1'b0;
    repeat (RST_AT - 1) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_ready", int'(dif.ready), 1);
    chk("mid_rst_done", int'(dif.done), 0);
    chk("mid_rst_turn", int'(turn), 0);
    chk("mid_rst_ok", int'(dif.ok), 0);
    chk("mid_rst_anim_active", int'(anim_active), 0);
    chk("mid_rst_anim_row", int'(anim_row), 0);
    chk_board_empty("mid_rst_board");
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= dif.done;
    end
    chk("post_rst_no_done", int'(seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
